// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register file write port.
// Holds one instruction from MEM, waits for late load data, selects the
// writeback source, stalls MEM while busy, sequences HALT and flags illegal
// writeback selects.
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_cnt output,
// a wrapping count of retired entries.
module wb_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_pc_inc,
  input  logic [1:0]            mem_wb_sel,
  input  logic                  mem_regwrite,
  input  logic [2:0]            mem_writeregsel,
  input  logic                  mem_halt,
  input  logic                  flush,
  output logic [2:0]            writeregsel,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic                  write,
  output logic                  halted,
  output logic                  err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [15:0]           retire_cnt
`endif
);

  typedef enum logic [1:0] {RUN, WAIT_MEM, HALTED} state_t;

  typedef struct packed {
    logic                  v;
    logic [1:0]            sel;
    logic                  rw;
    logic [2:0]            rd;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ld;
    logic                  halt;
  } entry_t;

  state_t state, state_nxt;
  entry_t ent;
  logic   transfer, cap, cap_ld, v_nxt, err_set;

  // MEM handshake is a pure state decode so MEM never sees a comb path.
  assign mem_ready = (state == RUN);
  assign halted    = (state == HALTED);
  assign transfer  = mem_valid & mem_ready;

  // Next state and entry capture control. A retiring halt entry wins over
  // flush and any new transfer; flush wins over accept and late load data.
  always_comb begin
    state_nxt = state;
    v_nxt     = 1'b0;
    cap       = 1'b0;
    cap_ld    = 1'b0;
    case (state)
      RUN: begin
        if (ent.v && ent.halt) begin
          state_nxt = HALTED;
        end else if (flush) begin
          state_nxt = RUN;
        end else if (transfer) begin
          cap = 1'b1;
          if (mem_wb_sel == 2'b01 && !mem_rd_valid) state_nxt = WAIT_MEM;
          else                                      v_nxt     = 1'b1;
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_nxt = RUN;
        end else if (mem_rd_valid) begin
          cap_ld    = 1'b1;
          v_nxt     = 1'b1;
          state_nxt = RUN;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
    err_set = cap & (mem_wb_sel == 2'b11);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Entry register: full capture on accept, load data only on late arrival.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent <= '0;
    end else begin
      ent.v <= v_nxt;
      if (cap) begin
        ent.sel  <= mem_wb_sel;
        ent.rw   <= mem_regwrite;
        ent.rd   <= mem_writeregsel;
        ent.alu  <= mem_alu_result;
        ent.pc   <= mem_pc_inc;
        ent.ld   <= mem_rd_data;
        ent.halt <= mem_halt;
      end else if (cap_ld) begin
        ent.ld   <= mem_rd_data;
      end
    end
  end

  // Sticky illegal-select flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Register file port decoded purely from the held entry.
  assign write       = ent.v & ent.rw & (ent.sel != 2'b11);
  assign writeregsel = ent.rd;

  // Writeback source select; illegal select drives zero.
  always_comb begin
    writedata = '0;
    case (ent.sel)
      2'b00:   writedata = ent.alu;
      2'b01:   writedata = ent.ld;
      2'b10:   writedata = ent.pc;
      default: writedata = '0;
    endcase
  end

`ifdef WB_RETIRE_CNT_EN
  // Count every retired entry, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       retire_cnt <= '0;
    else if (ent.v) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: table-driven ALU/load/PC vectors plus hand-written
// late-load, flush, illegal-select, reset and halt sequences. Expected writes
// go into a scoreboard queue (with the cycle they must appear in) when
// stimulus is driven; every negedge the write port is compared against it.
module tb_wb_stage;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, mem_ready, mem_rd_valid, mem_regwrite, mem_halt, flush;
  logic [DW-1:0] mem_alu_result, mem_rd_data, mem_pc_inc;
  logic [1:0]    mem_wb_sel;
  logic [2:0]    mem_writeregsel;
  logic [2:0]    writeregsel;
  logic [DW-1:0] writedata;
  logic          write, halted, err;
`ifdef WB_RETIRE_CNT_EN
  logic [15:0]   retire_cnt;
  logic [15:0]   cnt_before;
`endif

  wb_stage #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .mem_pc_inc(mem_pc_inc),
    .mem_wb_sel(mem_wb_sel), .mem_regwrite(mem_regwrite),
    .mem_writeregsel(mem_writeregsel), .mem_halt(mem_halt), .flush(flush),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .halted(halted), .err(err)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  typedef struct {
    logic [2:0]    rd;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]    sel;
    logic          rw;
    logic [2:0]    rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] ld;
    logic [DW-1:0] pc;
    logic          exp_w;
    logic [DW-1:0] exp_d;
  } vec_t;
  vec_t vt[8];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare the write port against the scoreboard.
  task automatic mon();
    exp_t e;
    if (sb.size() == 0) begin
      chk("write_unexpected", {31'b0, write}, 32'd0);
    end else if (write) begin
      e = sb.pop_front();
      chk("write_rd",    {29'b0, writeregsel}, {29'b0, e.rd});
      chk("write_data",  {16'b0, writedata},   {16'b0, e.data});
      chk("write_cycle", pcnt,                 e.cyc);
    end else if (pcnt > sb[0].cyc) begin
      chk("write_missing", pcnt, sb[0].cyc);
      void'(sb.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic idle();
    mem_valid = 0; mem_rd_valid = 0; flush = 0; mem_halt = 0;
    mem_wb_sel = 2'b00; mem_regwrite = 0; mem_writeregsel = 0;
    mem_alu_result = 0; mem_rd_data = 0; mem_pc_inc = 0;
  endtask

  task automatic drive(input logic [1:0] sel, input logic rw, input logic [2:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] ld,
                       input logic ldv, input logic [DW-1:0] pc, input logic hlt);
    mem_valid = 1; mem_wb_sel = sel; mem_regwrite = rw; mem_writeregsel = rd;
    mem_alu_result = alu; mem_rd_data = ld; mem_rd_valid = ldv;
    mem_pc_inc = pc; mem_halt = hlt; flush = 0;
  endtask

  task automatic expect_wr(input logic [2:0] rd, input logic [DW-1:0] d);
    exp_t e;
    e.rd = rd; e.data = d; e.cyc = pcnt + 1;
    sb.push_back(e);
  endtask

  initial begin
    vt[0] = '{2'b00, 1'b1, 3'd3, 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h1234};
    vt[1] = '{2'b01, 1'b1, 3'd5, 16'h0001, 16'hBEEF, 16'h0002, 1'b1, 16'hBEEF};
    vt[2] = '{2'b10, 1'b1, 3'd7, 16'h0003, 16'h0004, 16'h0042, 1'b1, 16'h0042};
    vt[3] = '{2'b00, 1'b0, 3'd2, 16'h7777, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vt[4] = '{2'b00, 1'b1, 3'd0, 16'hFFFF, 16'h1111, 16'h2222, 1'b1, 16'hFFFF};
    vt[5] = '{2'b01, 1'b1, 3'd1, 16'h3333, 16'h0000, 16'h4444, 1'b1, 16'h0000};
    vt[6] = '{2'b10, 1'b1, 3'd6, 16'h5555, 16'h6666, 16'hFFFE, 1'b1, 16'hFFFE};
    vt[7] = '{2'b00, 1'b1, 3'd4, 16'hA5A5, 16'h5A5A, 16'h0F0F, 1'b1, 16'hA5A5};

    idle();
    rst = 0;
    tick();
    // Reset state
    chk("rst_write",  {31'b0, write},       32'd0);
    chk("rst_data",   {16'b0, writedata},   32'd0);
    chk("rst_rd",     {29'b0, writeregsel}, 32'd0);
    chk("rst_halted", {31'b0, halted},      32'd0);
    chk("rst_err",    {31'b0, err},         32'd0);
    chk("rst_ready",  {31'b0, mem_ready},   32'd1);
    rst = 1;
    tick();

    // Back-to-back table vectors, one transfer per clock
    for (int i = 0; i < 8; i++) begin
      chk("tbl_ready", {31'b0, mem_ready}, 32'd1);
      drive(vt[i].sel, vt[i].rw, vt[i].rd, vt[i].alu, vt[i].ld, 1'b1, vt[i].pc, 1'b0);
      if (vt[i].exp_w) expect_wr(vt[i].rd, vt[i].exp_d);
      tick();
    end
    idle();
    tick(); tick();
    chk("tbl_err", {31'b0, err}, 32'd0);

    // Late load: WB stalls MEM for three clocks, then writes
    drive(2'b01, 1'b1, 3'd5, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    tick();
    chk("late_ready0", {31'b0, mem_ready}, 32'd0);
    drive(2'b00, 1'b1, 3'd2, 16'hDEAD, 16'hDEAD, 1'b0, 16'h0, 1'b0); // must be ignored
    tick();
    chk("late_ready1", {31'b0, mem_ready}, 32'd0);
    idle();
    tick();
    chk("late_ready2", {31'b0, mem_ready}, 32'd0);
    mem_rd_valid = 1; mem_rd_data = 16'hBEEF;
    expect_wr(3'd5, 16'hBEEF);
    tick();
    chk("late_ready3", {31'b0, mem_ready}, 32'd1);
    idle();
    tick(); tick();

    // Flush while waiting for load data, in the same cycle the data arrives
    drive(2'b01, 1'b1, 3'd6, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    tick();
    idle();
    tick();
    flush = 1; mem_rd_valid = 1; mem_rd_data = 16'h1111;
    tick();
    chk("flush_ready", {31'b0, mem_ready}, 32'd1);
    // Flush beats a transfer offered in the same cycle
    drive(2'b00, 1'b1, 3'd3, 16'h9999, 16'h0, 1'b1, 16'h0, 1'b0);
    flush = 1;
    tick();
    idle();
    tick(); tick();

    // Illegal select: retires silently, err sticks
`ifdef WB_RETIRE_CNT_EN
    cnt_before = retire_cnt;
`endif
    chk("ill_err_pre", {31'b0, err}, 32'd0);
    drive(2'b11, 1'b1, 3'd2, 16'h5555, 16'h6666, 1'b1, 16'h7777, 1'b0);
    tick();
    idle();
    chk("ill_write", {31'b0, write}, 32'd0);
    tick();
    chk("ill_err", {31'b0, err}, 32'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("ill_retire_cnt", {16'b0, retire_cnt}, {16'b0, cnt_before + 16'd1});
`endif
    drive(2'b00, 1'b1, 3'd1, 16'h0BAD, 16'h0, 1'b1, 16'h0, 1'b0);
    expect_wr(3'd1, 16'h0BAD);
    tick();
    idle();
    tick(); tick();
    chk("ill_err_sticky", {31'b0, err}, 32'd1);

    // Asynchronous reset while a load is waiting
    drive(2'b01, 1'b1, 3'd4, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    tick();
    idle();
    chk("midrst_ready_pre", {31'b0, mem_ready}, 32'd0);
    #2 rst = 0;
    #1;
    chk("midrst_ready", {31'b0, mem_ready}, 32'd1);
    chk("midrst_err",   {31'b0, err},       32'd0);
    tick();
    rst = 1;
    mem_rd_valid = 1; mem_rd_data = 16'hCAFE;
    tick();
    idle();
    tick(); tick();

    // Halt: the PC+2 link write retires, then the core stays halted
    drive(2'b10, 1'b1, 3'd7, 16'h0, 16'h0, 1'b1, 16'h0042, 1'b1);
    expect_wr(3'd7, 16'h0042);
    tick();
    idle();
    chk("halt_pre", {31'b0, halted}, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halted",       {31'b0, halted},    32'd1);
      chk("halted_ready", {31'b0, mem_ready}, 32'd0);
      drive(2'b00, 1'b1, 3'(i), 16'(i), 16'(i), 1'b1, 16'h0, 1'b0);
      flush = i[0];
      tick();
    end
    idle();
    rst = 0;
    tick();
    chk("halt_rst_halted", {31'b0, halted},    32'd0);
    chk("halt_rst_ready",  {31'b0, mem_ready}, 32'd1);
    rst = 1;
    tick();
    drive(2'b00, 1'b1, 3'd2, 16'h2468, 16'h0, 1'b1, 16'h0, 1'b0);
    expect_wr(3'd2, 16'h2468);
    tick();
    idle();
    tick(); tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
